// File: rtl/btn_debounce_counter_if.sv
// Signal bundle between the button conditioning stage and its consumer (RAM_MMIO or a bench).
// Carries the raw button, the clear strobes, the conditioned outputs and FSM debug visibility.
interface btn_debounce_counter_if #(
  parameter int COUNT_W = 8
);
  // Handshake: there is no valid/ready pair. Every output is a registered level that is
  // valid on every cycle; clr_pend/clr_cnt are acted on in each cycle they are high.
  logic               btn_in;
  logic               clr_pend;
  logic               clr_cnt;
  logic               btn_level;
  logic               press_pulse;
  logic [COUNT_W-1:0] press_count;
  logic               pending;
  logic [1:0]         dbg_state;
  logic [31:0]        dbg_cnt;

  modport master (
    output btn_in,
    output clr_pend,
    output clr_cnt,
    input  btn_level,
    input  press_pulse,
    input  press_count,
    input  pending,
    input  dbg_state,
    input  dbg_cnt
  );

  modport slave (
    input  btn_in,
    input  clr_pend,
    input  clr_cnt,
    output btn_level,
    output press_pulse,
    output press_count,
    output pending,
    output dbg_state,
    output dbg_cnt
  );
endinterface

// File: rtl/btn_debounce_counter.sv
// Synchronises and debounces a raw push-button, then derives a press pulse,
// a wrapping press counter and a sticky pending flag for the MMIO register block.
module btn_debounce_counter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  btn_debounce_counter_if.slave bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Encoding is visible on dbg_state: 0 IDLE_LOW, 1 WAIT_HIGH, 2 IDLE_HIGH, 3 WAIT_LOW.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic               s1_q, s2_q;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               pulse_q, pulse_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               pend_q, pend_d;
  logic               press;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      s1_q    <= bus.btn_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press   = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // A press coinciding with a clear keeps the press: count restarts at 1, pending stays set.
  always_comb begin
    pulse_d = press;
    count_d = count_q;
    if (press) begin
      count_d = bus.clr_cnt ? COUNT_W'(1) : count_q + COUNT_W'(1);
    end else if (bus.clr_cnt) begin
      count_d = '0;
    end
    pend_d = press | (pend_q & ~bus.clr_pend);
  end

  assign bus.btn_level   = level_q;
  assign bus.press_pulse = pulse_q;
  assign bus.press_count = count_q;
  assign bus.pending     = pend_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_cnt     = 32'(cnt_q);

  a_pulse_single: assert property (@(posedge clk) disable iff (!reset)
    pulse_q |=> !pulse_q);
  a_cnt_range: assert property (@(posedge clk) disable iff (!reset)
    cnt_q <= CNT_LAST);

endmodule
